// File: rtl/goertzel_pkg.sv
// Shared definitions for the Goertzel power detector: data width and the
// sequencing state encoding, which also appears on the debug state port.
package goertzel_pkg;

  localparam int POWER_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    START  = 2'd1,
    WAIT   = 2'd2,
    UPDATE = 2'd3
  } det_state_e;

endpackage

// File: rtl/goertzel_power_detector.sv
// Sequences back-to-back Goertzel windows, averages 2^AVG_LOG2 power results,
// and drives a hysteretic tone-detect flag plus a stalled-stage watchdog.
module goertzel_power_detector
  import goertzel_pkg::*;
#(
  parameter int AVG_LOG2       = 3,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable_i,
  input  logic [31:0]        power_i,
  input  logic               done_i,
  output logic               start_o,
  input  logic [31:0]        thresh_on_i,
  input  logic [31:0]        thresh_off_i,
  output logic [31:0]        avg_power_o,
  output logic               avg_valid_o,
  output logic               detect_o,
  output logic               timeout_o,
  output logic [1:0]         state_o
);

  localparam int ACC_W = POWER_W + AVG_LOG2;
  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  // Handshake: start_o is a single-cycle request to the power stage; the
  // stage answers with a rising edge on done_i while power_i holds its result.
  // Only the rising edge counts, so a level left high across start_o is ignored.

  det_state_e           state_q;
  logic [ACC_W-1:0]     acc_q;
  logic [ACC_W-1:0]     acc_d;
  logic [AVG_LOG2-1:0]  cnt_q;
  logic [TMR_W-1:0]     tmr_q;
  logic                 done_q;
  logic                 rise;
  logic                 last_win;
  logic                 tmr_exp;
  logic [POWER_W-1:0]   avg_d;

  assign rise     = done_i & ~done_q;
  assign acc_d    = acc_q + ACC_W'(power_i);
  assign avg_d    = acc_q[ACC_W-1:AVG_LOG2];
  assign last_win = &cnt_q;
  assign tmr_exp  = (tmr_q == TMR_LAST);
  assign state_o  = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      tmr_q       <= '0;
      done_q      <= 1'b0;
      start_o     <= 1'b0;
      avg_power_o <= '0;
      avg_valid_o <= 1'b0;
      detect_o    <= 1'b0;
      timeout_o   <= 1'b0;
    end else begin
      done_q      <= done_i;
      start_o     <= 1'b0;
      avg_valid_o <= 1'b0;
      timeout_o   <= 1'b0;
      case (state_q)
        IDLE: begin
          acc_q <= '0;
          cnt_q <= '0;
          if (enable_i) begin
            state_q <= START;
            start_o <= 1'b1;
          end
        end
        START: begin
          tmr_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          tmr_q <= tmr_q + TMR_W'(1);
          if (rise) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + AVG_LOG2'(1);
            if (last_win) begin
              state_q <= UPDATE;
            end else if (enable_i) begin
              state_q <= START;
              start_o <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end else if (tmr_exp) begin
            // Stalled stage: drop the partial average, keep the last decision.
            timeout_o <= 1'b1;
            acc_q     <= '0;
            cnt_q     <= '0;
            state_q   <= IDLE;
          end
        end
        UPDATE: begin
          avg_power_o <= avg_d;
          avg_valid_o <= 1'b1;
          if (!detect_o && (avg_d >= thresh_on_i)) begin
            detect_o <= 1'b1;
          end else if (detect_o && (avg_d < thresh_off_i)) begin
            detect_o <= 1'b0;
          end
          acc_q <= '0;
          cnt_q <= '0;
          if (enable_i) begin
            state_q <= START;
            start_o <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_goertzel_power_detector.sv
// Bench for goertzel_power_detector: emulates the power stage, keeps a
// group-average/hysteresis reference model and walks the detector's scenarios.
module tb_goertzel_power_detector;
  import goertzel_pkg::*;

  localparam int AVG_LOG2 = 2;
  localparam int N_AVG    = 4;
  localparam int TMO      = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable_i;
  logic [31:0] power_i;
  logic        done_i;
  logic        start_o;
  logic [31:0] thresh_on_i;
  logic [31:0] thresh_off_i;
  logic [31:0] avg_power_o;
  logic        avg_valid_o;
  logic        detect_o;
  logic        timeout_o;
  logic [1:0]  state_o;

  int n_cmp  = 0;
  int n_fail = 0;
  int start_cnt = 0;
  int valid_cnt = 0;
  int tmo_cnt   = 0;

  logic [31:0] exp_q[$];
  logic        exp_det_q[$];
  logic [31:0] win_q[$];
  logic        model_det;

  always #5 clk = ~clk;

  goertzel_power_detector #(
    .AVG_LOG2      (AVG_LOG2),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable_i    (enable_i),
    .power_i     (power_i),
    .done_i      (done_i),
    .start_o     (start_o),
    .thresh_on_i (thresh_on_i),
    .thresh_off_i(thresh_off_i),
    .avg_power_o (avg_power_o),
    .avg_valid_o (avg_valid_o),
    .detect_o    (detect_o),
    .timeout_o   (timeout_o),
    .state_o     (state_o)
  );

  // Pulse counters sampled mid-cycle; snapshots are taken 1 time unit later.
  always @(negedge clk) begin
    if (start_o === 1'b1)     start_cnt++;
    if (avg_valid_o === 1'b1) valid_cnt++;
    if (timeout_o === 1'b1)   tmo_cnt++;
  end

  // Reference model: every N_AVG accepted powers form one truncated mean,
  // then the hysteresis rule decides the flag.
  task automatic model_window(input logic [31:0] p);
    longint unsigned sum;
    logic [31:0] avg;
    win_q.push_back(p);
    if (win_q.size() == N_AVG) begin
      sum = 0;
      foreach (win_q[i]) sum += longint'(win_q[i]);
      avg = 32'(sum / N_AVG);
      if (!model_det && avg >= thresh_on_i)     model_det = 1'b1;
      else if (model_det && avg < thresh_off_i) model_det = 1'b0;
      exp_q.push_back(avg);
      exp_det_q.push_back(model_det);
      win_q.delete();
    end
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (start_o !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (start_o !== 1'b1) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_start_wait: start_o=%b after %0d cycles, required 1", tag, start_o, n);
    end
  endtask

  // Power-stage driver: answers the pending start_o with one done_i pulse.
  task automatic run_window(input logic [31:0] p, input int dly);
    wait_start("window");
    @(negedge clk);
    repeat (dly) @(negedge clk);
    power_i = p;
    done_i  = 1'b1;
    model_window(p);
    @(negedge clk);
    done_i  = 1'b0;
    power_i = $urandom;
  endtask

  task automatic drive_group(input logic [31:0] p[4], output logic pre_v,
                             output logic v, output logic [31:0] a, output logic d);
    for (int i = 0; i < N_AVG; i++) run_window(p[i], int'($urandom_range(0, 5)));
    pre_v = avg_valid_o;
    @(negedge clk);
    v = avg_valid_o;
    a = avg_power_o;
    d = detect_o;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable_i = 1'b1; done_i = 1'b0; power_i = '0;
    thresh_on_i = '0; thresh_off_i = '0; model_det = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({start_o, avg_valid_o, detect_o, timeout_o, avg_power_o, state_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: start=%b valid=%b det=%b tmo=%b avg=%h state=%0d, required all 0",
               start_o, avg_valid_o, detect_o, timeout_o, avg_power_o, state_o);
    end
    n_cmp++;
    if (start_cnt != 0) begin
      n_fail++;
      $display("FAIL reset_no_start: %0d start pulses during reset, required 0", start_cnt);
    end
    enable_i = 1'b0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_average_detect();
    logic [31:0] p[4];
    logic pre_v, v, d, ed;
    logic [31:0] a, ea;
    int s0, v0;
    thresh_on_i = 32'd200; thresh_off_i = 32'd100;
    #1 s0 = start_cnt; v0 = valid_cnt;
    enable_i = 1'b1;
    p = '{32'd100, 32'd200, 32'd300, 32'd400};
    drive_group(p, pre_v, v, a, d);
    ea = exp_q.pop_front(); ed = exp_det_q.pop_front();
    n_cmp++;
    if (pre_v !== 1'b0 || v !== 1'b1) begin
      n_fail++;
      $display("FAIL avg_latency: valid one edge after rise=%b, two edges=%b, required 0 then 1", pre_v, v);
    end
    n_cmp++;
    if (a !== ea) begin n_fail++; $display("FAIL avg_250: got %0d required %0d", a, ea); end
    n_cmp++;
    if (d !== ed) begin n_fail++; $display("FAIL detect_on: got %b required %b", d, ed); end
    #1;
    // Four starts for the group plus the next window's start beside avg_valid_o.
    n_cmp++;
    if (start_cnt - s0 != N_AVG + 1) begin
      n_fail++; $display("FAIL start_count: got %0d required %0d", start_cnt - s0, N_AVG + 1);
    end
    n_cmp++;
    if (valid_cnt - v0 != 1) begin
      n_fail++; $display("FAIL valid_count: got %0d required 1", valid_cnt - v0);
    end
  endtask

  task automatic test_hysteresis();
    logic [31:0] p[4];
    logic pre_v, v, d, ed;
    logic [31:0] a, ea;
    p = '{32'd150, 32'd150, 32'd150, 32'd150};
    drive_group(p, pre_v, v, a, d);
    ea = exp_q.pop_front(); ed = exp_det_q.pop_front();
    n_cmp++;
    if (v !== 1'b1 || a !== ea || d !== ed) begin
      n_fail++; $display("FAIL hyst_hold: valid=%b avg=%0d det=%b required 1 %0d %b", v, a, d, ea, ed);
    end
    p = '{32'd50, 32'd50, 32'd50, 32'd50};
    drive_group(p, pre_v, v, a, d);
    ea = exp_q.pop_front(); ed = exp_det_q.pop_front();
    n_cmp++;
    if (v !== 1'b1 || a !== ea || d !== ed) begin
      n_fail++; $display("FAIL hyst_release: valid=%b avg=%0d det=%b required 1 %0d %b", v, a, d, ea, ed);
    end
  endtask

  task automatic test_sticky_done();
    logic v, d, ed;
    logic [31:0] a, ea;
    int v0;
    #1 v0 = valid_cnt;
    wait_start("sticky");
    repeat (3) @(negedge clk);
    power_i = 32'd10; done_i = 1'b1; model_window(32'd10);
    @(negedge clk);
    wait_start("sticky_next");
    repeat (5) @(negedge clk);
    done_i = 1'b0;
    @(negedge clk);
    power_i = 32'd20; done_i = 1'b1; model_window(32'd20);
    @(negedge clk);
    done_i = 1'b0;
    run_window(32'd30, 2);
    #1;
    n_cmp++;
    if (valid_cnt != v0) begin
      n_fail++; $display("FAIL sticky_early_avg: %0d averages after 3 windows, required 0", valid_cnt - v0);
    end
    run_window(32'd40, 1);
    @(negedge clk);
    v = avg_valid_o; a = avg_power_o; d = detect_o;
    ea = exp_q.pop_front(); ed = exp_det_q.pop_front();
    n_cmp++;
    if (v !== 1'b1 || a !== ea || d !== ed) begin
      n_fail++; $display("FAIL sticky_avg: valid=%b avg=%0d det=%b required 1 %0d %b", v, a, d, ea, ed);
    end
  endtask

  task automatic test_timeout();
    int v0, t0, n;
    #1 v0 = valid_cnt; t0 = tmo_cnt;
    wait_start("timeout");
    n = 0;
    while (timeout_o !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    // The start cycle is followed by TMO cycles of WAIT, then the pulse.
    n_cmp++;
    if (n != TMO + 1) begin
      n_fail++; $display("FAIL timeout_delay: pulse %0d cycles after start, required %0d", n, TMO + 1);
    end
    #1;
    n_cmp++;
    if (valid_cnt != v0 || tmo_cnt - t0 != 1) begin
      n_fail++; $display("FAIL timeout_pulses: valid=%0d tmo=%0d, required 0 and 1", valid_cnt - v0, tmo_cnt - t0);
    end
    @(negedge clk);
    n_cmp++;
    if (start_o !== 1'b1 || timeout_o !== 1'b0) begin
      n_fail++; $display("FAIL timeout_restart: start=%b tmo=%b, required 1 and 0", start_o, timeout_o);
    end
  endtask

  task automatic test_extremes();
    logic [31:0] p[4];
    logic pre_v, v, d, ed;
    logic [31:0] a, ea;
    thresh_on_i = 32'hFFFF_FFFF; thresh_off_i = 32'h8000_0000;
    p = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    drive_group(p, pre_v, v, a, d);
    ea = exp_q.pop_front(); ed = exp_det_q.pop_front();
    n_cmp++;
    if (v !== 1'b1 || a !== ea || d !== ed) begin
      n_fail++; $display("FAIL extremes: valid=%b avg=%h det=%b required 1 %h %b", v, a, d, ea, ed);
    end
  endtask

  task automatic test_reset_mid();
    int s0, n;
    wait_start("reset_mid");
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({start_o, avg_valid_o, detect_o, timeout_o, avg_power_o, state_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_async: det=%b avg=%h state=%0d start=%b, required all 0",
               detect_o, avg_power_o, state_o, start_o);
    end
    s0 = start_cnt;
    model_det = 1'b0;
    win_q.delete();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (start_cnt != s0) begin
      n_fail++; $display("FAIL reset_hold_start: %0d starts while in reset, required 0", start_cnt - s0);
    end
    rst = 1'b0;
    n = 0;
    while (start_o !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (n != 1) begin
      n_fail++; $display("FAIL reset_release_start: start after %0d cycles, required 1", n);
    end
  endtask

  task automatic test_random();
    logic [31:0] p[4];
    logic pre_v, v, d, ed;
    logic [31:0] a, ea;
    for (int g = 0; g < 6; g++) begin
      thresh_on_i  = $urandom_range(200, 800);
      thresh_off_i = $urandom_range(0, int'(thresh_on_i));
      for (int i = 0; i < N_AVG; i++) p[i] = (g == 5) ? $urandom : $urandom_range(0, 1000);
      drive_group(p, pre_v, v, a, d);
      ea = exp_q.pop_front(); ed = exp_det_q.pop_front();
      n_cmp++;
      if (v !== 1'b1 || a !== ea || d !== ed) begin
        n_fail++;
        $display("FAIL random_g%0d: valid=%b avg=%0d det=%b required 1 %0d %b", g, v, a, d, ea, ed);
      end
    end
  endtask

  task automatic test_enable_abort();
    logic [31:0] p[4];
    logic pre_v, v, d, ed;
    logic [31:0] a, ea;
    int s0, v0;
    run_window(32'd900, 1);
    enable_i = 1'b0;
    run_window(32'd900, 2);
    #1 s0 = start_cnt; v0 = valid_cnt;
    win_q.delete();
    repeat (20) @(negedge clk);
    n_cmp++;
    if (start_cnt != s0 || valid_cnt != v0 || state_o !== 2'(IDLE)) begin
      n_fail++;
      $display("FAIL abort_idle: starts=%0d valids=%0d state=%0d, required 0 0 %0d",
               start_cnt - s0, valid_cnt - v0, state_o, IDLE);
    end
    enable_i = 1'b1;
    thresh_on_i = 32'd500; thresh_off_i = 32'd300;
    p = '{32'd4, 32'd8, 32'd12, 32'd17};
    drive_group(p, pre_v, v, a, d);
    ea = exp_q.pop_front(); ed = exp_det_q.pop_front();
    n_cmp++;
    if (v !== 1'b1 || a !== ea || d !== ed) begin
      n_fail++; $display("FAIL abort_fresh_avg: valid=%b avg=%0d det=%b required 1 %0d %b", v, a, d, ea, ed);
    end
  endtask

  initial begin
    test_reset();
    test_average_detect();
    test_hysteresis();
    test_sticky_done();
    test_timeout();
    test_extremes();
    test_reset_mid();
    test_random();
    test_enable_abort();
    enable_i = 1'b0;
    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_cmp++;
    n_fail++;
    $display("FAIL global_time_limit: simulation exceeded 200000 time units");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
